// File: rtl/ro_sampler_pkg.sv
// Shared types and helpers for the ring-oscillator window sampler.
// Holds the FSM state type, default widths and a popcount helper.
package ro_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_t;

  localparam int N_RO_DEF       = 25;
  localparam int SUM_W_DEF      = 24;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int CFG_W          = 16;
  localparam int POP_MAX        = 64;

  function automatic logic [6:0] popcount(input logic [POP_MAX-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + 7'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ro_sample_fifo.sv
// First-word fall-through sample FIFO with flush and level output.
// A push on a full FIFO is accepted only when a pop frees a slot.
module ro_sample_fifo
  import ro_sampler_pkg::*;
#(
  parameter int W     = SUM_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // sample storage, contents only meaningful below level
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ro_window_sampler.sv
// Ring-oscillator capture stage: counts edge strobes per window after
// a trigger and queues one saturated sum per window for readout.
module ro_window_sampler
  import ro_sampler_pkg::*;
#(
  parameter int N_RO       = N_RO_DEF,
  parameter int SUM_W      = SUM_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1,
  localparam int PC_W      = $clog2(N_RO + 1)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [N_RO-1:0]  ro_edge,
  input  logic             trig,
  input  logic             arm,
  input  logic             abort,
  input  logic [CFG_W-1:0] cfg_window,
  input  logic [CFG_W-1:0] cfg_nsamples,
  input  logic             pop,
  output logic [SUM_W-1:0] sample_data,
  output logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [LVL_W-1:0] fifo_level
);

  state_t           state;
  state_t           state_nxt;
  logic             trig_q;
  logic [SUM_W-1:0] acc;
  logic [CFG_W-1:0] win_cnt;
  logic [CFG_W-1:0] smp_cnt;
  logic [CFG_W-1:0] win_len;
  logic [CFG_W-1:0] n_len;
  logic [PC_W-1:0]  pc;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_sat;
  logic             arm_go;
  logic             win_end;
  logic             push;
  logic             last;
  logic             fifo_full;
  logic             fifo_empty;

  assign pc      = PC_W'(popcount(POP_MAX'(ro_edge)));
  assign sum_ext = {1'b0, acc} + (SUM_W+1)'(pc);
  assign sum_sat = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
  assign arm_go  = arm && !abort && (state == IDLE);
  assign win_end = (state == CAPTURE) && (win_cnt == win_len - 1'b1);
  assign push    = win_end && !abort;
  assign last    = push && (smp_cnt == n_len - 1'b1);

  assign busy         = (state == ARMED) || (state == CAPTURE);
  assign done         = (state == DONE);
  assign sample_valid = !fifo_empty;

  // state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; abort overrides every transition
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arm_go) state_nxt = ARMED;
      ARMED:   if (trig && !trig_q) state_nxt = CAPTURE;
      CAPTURE: if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // trigger history, config latch, accumulator and counters
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      trig_q  <= 1'b0;
      acc     <= '0;
      win_cnt <= '0;
      smp_cnt <= '0;
      win_len <= '0;
      n_len   <= '0;
    end else begin
      trig_q <= trig;
      if (abort) begin
        acc     <= '0;
        win_cnt <= '0;
        smp_cnt <= '0;
      end else if (arm_go) begin
        win_len <= (cfg_window == '0) ? CFG_W'(1) : cfg_window;
        n_len   <= (cfg_nsamples == '0) ? CFG_W'(1) : cfg_nsamples;
        acc     <= '0;
        win_cnt <= '0;
        smp_cnt <= '0;
      end else if (state == CAPTURE) begin
        if (win_end) begin
          acc     <= '0;
          win_cnt <= '0;
          smp_cnt <= smp_cnt + 1'b1;
        end else begin
          acc     <= sum_sat;
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

  // sticky drop flag, cleared when a new capture is armed
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)  overflow <= 1'b0;
    else if (arm_go) overflow <= 1'b0;
    else if (push && fifo_full && !(pop && !fifo_empty)) overflow <= 1'b1;
  end

  ro_sample_fifo #(
    .W     (SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .flush (arm_go),
    .push  (push),
    .pop   (pop),
    .din   (sum_sat),
    .dout  (sample_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_ro_window_sampler.sv
// Directed and randomized bench for ro_window_sampler with a queue model.
// Uses an 8-bit sum so that window saturation is reachable.
module tb_ro_window_sampler;

  localparam int NRO   = 25;
  localparam int SW    = 8;
  localparam int DEPTH = 16;
  localparam int SMAX  = 255;

  logic           clk;
  logic           ARESET;
  logic [NRO-1:0] ro_edge;
  logic           trig;
  logic           arm;
  logic           abort;
  logic [15:0]    cfg_window;
  logic [15:0]    cfg_nsamples;
  logic           pop;
  logic [SW-1:0]  sample_data;
  logic           sample_valid;
  logic           busy;
  logic           done;
  logic           overflow;
  logic [4:0]     fifo_level;

  int passed;
  int fails;
  int total;
  int q[$];

  ro_window_sampler #(
    .N_RO       (NRO),
    .SUM_W      (SW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .ACLK         (clk),
    .ARESET       (ARESET),
    .ro_edge      (ro_edge),
    .trig         (trig),
    .arm          (arm),
    .abort        (abort),
    .cfg_window   (cfg_window),
    .cfg_nsamples (cfg_nsamples),
    .pop          (pop),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one full capture; mode 0 all edges, 1 sparse, 2 random
  // popmode 0 never, 1 only when full, 2 random
  task automatic run_cap(input int w, input int n, input int mode,
                         input int popmode);
    int ew;
    int en;
    int sum;
    int k;
    int last;
    bit ovf;
    bit pp;
    bit popeff;
    logic [NRO-1:0] e;
    ew  = (w == 0) ? 1 : w;
    en  = (n == 0) ? 1 : n;
    sum = 0;
    k   = 0;
    ovf = 0;
    last = ew * en - 1;
    q.delete();
    cfg_window   = 16'(w);
    cfg_nsamples = 16'(n);
    trig = 1'b0;
    arm  = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_busy", 32'(busy), 1);
    check("arm_level", 32'(fifo_level), 0);
    check("arm_ovf", 32'(overflow), 0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int c = 0; c <= last; c++) begin
      unique case (mode)
        0:       e = '1;
        1:       e = (c % 2 == 0) ? NRO'(1) : '0;
        default: e = NRO'($urandom);
      endcase
      ro_edge = e;
      if (popmode == 0)      pp = 0;
      else if (popmode == 1) pp = (q.size() == DEPTH);
      else                   pp = 1'($urandom);
      pop    = pp;
      popeff = pp && (q.size() > 0);
      if (popeff) check("pop_head", 32'(sample_data), q[0]);
      sum += $countones(e);
      k++;
      tick();
      if (popeff) void'(q.pop_front());
      if (k == ew) begin
        if (q.size() < DEPTH) q.push_back((sum > SMAX) ? SMAX : sum);
        else ovf = 1;
        sum = 0;
        k   = 0;
      end
      check("cap_level", 32'(fifo_level), q.size());
      check("cap_done", 32'(done), (c == last) ? 1 : 0);
      check("cap_busy", 32'(busy), (c == last) ? 0 : 1);
    end
    ro_edge = '0;
    pop     = 1'b0;
    check("end_ovf", 32'(overflow), 32'(ovf));
    check("end_valid", 32'(sample_valid), (q.size() > 0) ? 1 : 0);
    if (q.size() > 0) check("end_head", 32'(sample_data), q[0]);
    tick();
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
  endtask

  // pop everything the model expects and compare each head
  task automatic drain();
    while (q.size() > 0) begin
      check("drain_head", 32'(sample_data), q[0]);
      pop = 1'b1;
      tick();
      void'(q.pop_front());
      check("drain_level", 32'(fifo_level), q.size());
    end
    pop = 1'b0;
    check("drain_valid", 32'(sample_valid), 0);
    check("drain_data", 32'(sample_data), 0);
  endtask

  initial begin
    passed = 0;
    fails  = 0;
    total  = 0;
    ARESET = 1'b1;
    ro_edge = '0;
    trig = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    cfg_window = '0;
    cfg_nsamples = '0;
    pop = 1'b0;
    tick();
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_data", 32'(sample_data), 0);
    @(negedge clk);
    ARESET = 1'b0;
    tick();

    // basic capture: three samples of 100
    run_cap(4, 3, 0, 0);
    check("basic_len", 32'(q.size()), 3);
    check("basic_val", 32'(q[2]), 100);
    drain();

    // sparse edges: one sample of 5
    run_cap(10, 1, 1, 0);
    check("sparse_val", 32'(q[0]), 5);
    drain();

    // overflow with no pop, then re-arm clears it
    run_cap(1, 20, 0, 0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_level", 32'(fifo_level), 16);
    check("ovf_head", 32'(sample_data), 25);
    cfg_window = 16'd1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("rearm_level", 32'(fifo_level), 0);
    check("rearm_ovf", 32'(overflow), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("rearm_abort", 32'(busy), 0);

    // full FIFO with simultaneous push and pop
    run_cap(1, 20, 2, 1);
    check("fullpop_ovf", 32'(overflow), 0);
    check("fullpop_lvl", 32'(fifo_level), 16);
    drain();

    // abort mid-window keeps earlier sample
    cfg_window = 16'd5;
    cfg_nsamples = 16'd3;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    ro_edge = '1;
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ro_edge = '0;
    check("abort_busy", 32'(busy), 0);
    check("abort_level", 32'(fifo_level), 1);
    check("abort_head", 32'(sample_data), 125);
    repeat (3) tick();
    check("abort_hold", 32'(fifo_level), 1);

    // trigger held high through arm must not fire
    cfg_window = 16'd1;
    cfg_nsamples = 16'd0;
    trig = 1'b1;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    ro_edge = '1;
    repeat (5) tick();
    check("held_busy", 32'(busy), 1);
    check("held_level", 32'(fifo_level), 0);
    trig = 1'b0;
    tick();
    trig = 1'b1;
    tick();
    tick();
    check("held_done", 32'(done), 1);
    check("held_head", 32'(sample_data), 25);
    trig = 1'b0;
    ro_edge = '0;
    tick();

    // saturation at 8 bits
    run_cap(20, 1, 0, 0);
    check("sat_val", 32'(sample_data), 255);
    drain();

    // randomized captures
    for (int r = 0; r < 8; r++) begin
      run_cap(int'($urandom_range(0, 14)), int'($urandom_range(0, 6)), 2, 2);
      drain();
    end

    // asynchronous reset mid-capture
    cfg_window = 16'd20;
    cfg_nsamples = 16'd5;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    ro_edge = '1;
    repeat (25) tick();
    check("pre_rst_lvl", 32'(fifo_level), 1);
    #2;
    ARESET = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_level", 32'(fifo_level), 0);
    check("arst_valid", 32'(sample_valid), 0);
    check("arst_data", 32'(sample_data), 0);
    check("arst_done", 32'(done), 0);
    @(negedge clk);
    ARESET = 1'b0;
    ro_edge = '0;
    tick();
    check("arst_after", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
